// File: rtl/button_debouncer_if.sv
// Raw button levels in, debounced levels and press/release pulses out.
// The debouncer takes the slave view; the stimulus side takes the master view.
interface button_debouncer_if #(
  parameter int N_BTN = 2
);
  logic [N_BTN-1:0] i_btn;
  logic [N_BTN-1:0] o_btn;
  logic [N_BTN-1:0] o_press;
  logic [N_BTN-1:0] o_release;

  modport master (output i_btn, input o_btn, o_press, o_release);
  modport slave  (input i_btn, output o_btn, o_press, o_release);
endinterface

// File: rtl/button_debouncer.sv
// Per-channel 2-flop synchroniser plus 4-state debounce FSM with a stability counter.
// Each channel produces a clean level and single-cycle press/release pulses, all registered.
module button_debouncer #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  button_debouncer_if.slave bus
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  for (genvar n = 0; n < N_BTN; n++) begin : g_chan
    logic             s1;
    logic             s2;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             rel_q;
    logic             rel_d;
    logic             accept;

    // The raw input is asynchronous; only s2 is safe to look at.
    // NOTE: non-blocking assignments make s2 take the old s1, forming two real flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= bus.i_btn[n];
        s2 <= s1;
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state_q <= STABLE_LO;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    // Counter saturates at CNT_LAST by leaving WAIT_*, so it never wraps.
    assign accept = (cnt_q == CNT_LAST);

    always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        STABLE_LO: begin
          if (s2) begin
            state_d = WAIT_HI;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        WAIT_HI: begin
          if (!s2) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (accept) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s2) begin
            state_d = WAIT_LO;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        WAIT_LO: begin
          if (s2) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (accept) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      endcase
    end

    // Pulses are computed from the accepting transition and registered with the level.
    always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      if (state_q == WAIT_HI && s2 && accept) begin
        level_d = 1'b1;
        press_d = 1'b1;
      end else if (state_q == WAIT_LO && !s2 && accept) begin
        level_d = 1'b0;
        rel_d   = 1'b1;
      end
    end

    assign bus.o_btn[n]     = level_q;
    assign bus.o_press[n]   = press_q;
    assign bus.o_release[n] = rel_q;
  end
endmodule
